key_ascii_fifo: RTL and testbench
=================================

// Module: key_ascii_fifo
// PURPOSE
// - Converts keypad scan codes to ASCII characters and buffers them in a DEPTH-entry FIFO.
// - Delivers them over a valid/ready stream to the LCD/UART text path.
// - Parametrised successor of the combinational key-to-ASCII table: adds configurable code width,
//   code polarity, buffering, overflow tracking and an optional backspace mode.
// PARAMETERS
// - CODE_W   4  key code width, >=4; bits [CODE_W-1:4] must be zero for a legal code
// - DEPTH    8  FIFO entries, power of two, >=2
// - INV_CODE 1  1: index = ~key_code[3:0] (code 4'hF -> '0'); 0: index = key_code[3:0]
// - AW       $clog2(DEPTH)  derived pointer width, not to be overridden
// PORTS
// - clk        in   1       system clock, all logic on rising edge
// - rst_n      in   1       asynchronous active-low reset
// - key_code   in   CODE_W  scan code, sampled only when key_valid=1
// - key_valid  in   1       one-cycle strobe per key press
// - chr_data   out  8       ASCII of FIFO head, valid when chr_valid=1
// - chr_valid  out  1       FIFO not empty
// - chr_ready  in   1       consumer accepts head this cycle
// - count      out  AW+1    entries held, 0..DEPTH
// - full       out  1       count==DEPTH
// - empty      out  1       count==0
// - overflow   out  1       sticky: a key was dropped because the FIFO was full
// - clr_ovf    in   1       clears overflow
// BEHAVIOUR
// - Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n).
// - Reset values: count=0, empty=1, full=0, chr_valid=0, overflow=0, chr_data=8'h20, pointers=0.
// - Mapping (idx = 4-bit index after INV_CODE):
//   - 0-9 -> 8'h30-8'h39
//   - 10-13 -> 'A'-'D' (8'h41-8'h44)
//   - 14 -> '*' (8'h2A)
//   - 15 -> ' ' (8'h20)
// - Illegal code (any bit above bit 3 set) -> '?' (8'h3F), still pushed.
// - push = key_valid & (~full | pop); pop = chr_valid & chr_ready.
// - Latency: a key pushed into an empty FIFO at edge N shows chr_valid=1 with its chr_data
//   after edge N (first-word-fall-through). chr_data holds the head; it is stable while chr_valid=1
//   and chr_ready=0.
// - Simultaneous push and pop:
//   - Both apply and count is unchanged, including when full.
//   - When empty, pop is impossible and only the push applies.
// - Full:
//   - key_valid with full=1 and no pop drops the key; pointers and count are unchanged.
//   - overflow is set on the next edge.
// - overflow:
//   - clr_ovf=1 clears it.
//   - If a drop and clr_ovf occur in the same cycle, set wins.
// - Pointers wrap modulo DEPTH; count saturates neither way, because the push/pop qualification
//   keeps it in range.
// - Reset mid-operation:
//   - All entries are discarded immediately (asynchronous).
//   - The first key after rst_n deasserts is accepted normally.
// CONFIGURATION
// - KEY_BACKSPACE_EN undefined: idx 14 pushes '*' (8'h2A) like any other key.
// - KEY_BACKSPACE_EN defined: idx 14 is never stored. It deletes the newest unread entry
//   (write pointer -1, count -1).
//   - Empty FIFO: ignored; overflow is not affected.
//   - Full FIFO: allowed, never an overflow.
//   - Backspace together with a pop:
//     - count==1: the single entry is removed once and count becomes 0.
//     - count>=2: both apply and count drops by 2.
// TESTING
// - Reset, then feed key_code=4'hF,4'h6,4'h5,4'h1,4'h0 with INV_CODE=1 and chr_ready=1:
//   outputs '0','9','A','*',' ' (8'h30,39,41,2A,20), each 1 cycle after its strobe.
// - chr_ready=0, push 9 keys into DEPTH=8: full=1 and count=8 after 8 keys. The 9th is dropped
//   and overflow=1. Drain yields the first 8 in order. clr_ovf clears overflow.
// - Full FIFO with key_valid and chr_ready both 1: key accepted, count stays 8, no overflow.
// - CODE_W=6, key_code=6'h1F: '?' (8'h3F) pushed; key_code=6'h0F: '0'.
// - rst_n low for 1 cycle with count=5, asynchronous to clk: count=0 and chr_valid=0 immediately;
//   the next key is output correctly.
// - KEY_BACKSPACE_EN with keys '1','2' then code 4'h1 (idx 14): count=1, head '1'.
//   Backspace on empty: no change, overflow=0.

Source files
------------

// File: rtl/key_ascii_fifo.sv
// Keypad scan code to ASCII converter with a first-word-fall-through FIFO and a sticky overflow flag.
// Optional macro KEY_BACKSPACE_EN: index 14 deletes the newest unread entry instead of storing '*'.
module key_ascii_fifo #(
  parameter int CODE_W   = 4,
  parameter int DEPTH    = 8,
  parameter int INV_CODE = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_valid,
  output logic [7:0]        chr_data,
  output logic              chr_valid,
  input  logic              chr_ready,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam logic [AW-1:0] PTR_ONE   = 1;
  localparam logic [AW:0]   CNT_ONE   = 1;
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  function automatic logic [3:0] code_index(input logic [CODE_W-1:0] code);
    return (INV_CODE != 0) ? ~code[3:0] : code[3:0];
  endfunction

  function automatic logic code_illegal(input logic [CODE_W-1:0] code);
    logic [CODE_W+3:0] ext;
    ext = {4'b0000, code};
    return (ext >> 4) != '0;
  endfunction

  function automatic logic [7:0] ascii_of(input logic [3:0] idx, input logic bad);
    logic [7:0] c;
    if (bad) c = 8'h3F;
    else if (idx <= 4'd9) c = 8'h30 + {4'h0, idx};
    else if (idx <= 4'd13) c = 8'h41 + {4'h0, idx - 4'd10};
    else if (idx == 4'd14) c = 8'h2A;
    else c = 8'h20;
    return c;
  endfunction

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [3:0]    idx_p0;
  logic          bad_p0, bsp_p0;
  logic [7:0]    ascii_p0;
  logic          pop, push, drop, bsp_del;

  // Stage 0: decode the incoming scan code
  assign idx_p0   = code_index(key_code);
  assign bad_p0   = code_illegal(key_code);
  assign ascii_p0 = ascii_of(idx_p0, bad_p0);

`ifdef KEY_BACKSPACE_EN
  assign bsp_p0 = key_valid & ~bad_p0 & (idx_p0 == 4'd14);
`else
  assign bsp_p0 = 1'b0;
`endif

  assign empty     = (cnt == '0);
  assign full      = (cnt == CNT_DEPTH);
  assign chr_valid = ~empty;
  assign count     = cnt;
  assign chr_data  = empty ? 8'h20 : mem[rd_ptr];

  assign pop     = chr_valid & chr_ready;
  assign push    = key_valid & ~bsp_p0 & (~full | pop);
  assign drop    = key_valid & ~bsp_p0 & full & ~pop;
  // A backspace racing the pop of the only entry removes that entry just once
  assign bsp_del = bsp_p0 & ~empty & ~(pop & (cnt == CNT_ONE));

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    cnt_nxt    = cnt;
    if (pop) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
      cnt_nxt    = cnt_nxt - CNT_ONE;
    end
    if (push) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
      cnt_nxt    = cnt_nxt + CNT_ONE;
    end
    if (bsp_del) begin
      wr_ptr_nxt = wr_ptr - PTR_ONE;
      cnt_nxt    = cnt_nxt - CNT_ONE;
    end
  end

  // Stage 1: storage and control state
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ascii_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
      if (drop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_ascii_fifo.sv
// Self-checking bench for key_ascii_fifo (CODE_W=6, DEPTH=8, INV_CODE=1) with a queue scoreboard.
module tb_key_ascii_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic [7:0] chr_data;
  logic       chr_valid;
  logic       chr_ready = 1'b0;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic       clr_ovf = 1'b0;

  int tests = 0;
  int failed = 0;

  logic [7:0] q[$];
  logic       ovf_m = 1'b0;
  logic [127:0] tbl = "0123456789ABCD* ";

`ifdef KEY_BACKSPACE_EN
  localparam bit BSP_EN = 1'b1;
`else
  localparam bit BSP_EN = 1'b0;
`endif

  key_ascii_fifo #(.CODE_W(6), .DEPTH(8), .INV_CODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .chr_data(chr_data), .chr_valid(chr_valid), .chr_ready(chr_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_ascii(input logic [5:0] code);
    logic [3:0] i;
    logic [127:0] t;
    t = tbl;
    i = ~code[3:0];
    if (code[5:4] != 2'b00) return 8'h3F;
    return t[8*(15-i) +: 8];
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(count), 32'(q.size()));
    check({tag, ".valid"}, 32'(chr_valid), 32'(q.size() > 0));
    check({tag, ".full"}, 32'(full), 32'(q.size() == 8));
    check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    check({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
    if (q.size() > 0) check({tag, ".head"}, 32'(chr_data), 32'(q[0]));
  endtask

  // Called just after an active edge; returns just after the next one.
  task automatic step(input logic [5:0] code, input logic kv, input logic rdy, input logic clr,
                      input string tag);
    int  n;
    bit  pop_m, bsp_m;
    key_code = code; key_valid = kv; chr_ready = rdy; clr_ovf = clr;
    #1;
    n     = q.size();
    pop_m = rdy && (n > 0);
    bsp_m = BSP_EN && kv && (code[5:4] == 2'b00) && (~code[3:0] == 4'd14);
    if (pop_m) check({tag, ".pop"}, 32'(chr_data), 32'(q.pop_front()));
    if (kv && !bsp_m) begin
      if (n < 8 || pop_m) q.push_back(model_ascii(code));
      else ovf_m = 1'b1;
    end
    if (!(kv && !bsp_m && n == 8 && !pop_m) && clr) ovf_m = 1'b0;
    if (bsp_m && n > 0 && !(pop_m && n == 1)) void'(q.pop_back());
    @(posedge clk); #1;
    key_valid = 1'b0; clr_ovf = 1'b0;
    check_state(tag);
  endtask

  typedef struct {
    logic [5:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{6'h0F, 8'h30};
    vecs[1] = '{6'h06, 8'h39};
    vecs[2] = '{6'h05, 8'h41};
    vecs[3] = '{6'h01, 8'h20 + 8'h0A};
    vecs[4] = '{6'h00, 8'h20};
    vecs[5] = '{6'h1F, 8'h3F};
    vecs[6] = '{6'h0F, 8'h30};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.count", 32'(count), 0);
    check("rst.empty", 32'(empty), 1);
    check("rst.full", 32'(full), 0);
    check("rst.valid", 32'(chr_valid), 0);
    check("rst.ovf", 32'(overflow), 0);
    check("rst.data", 32'(chr_data), 32'h20);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapping table with consumer always ready (idx14 entry skipped when backspace is enabled)
    for (int i = 0; i < 7; i++) begin
      if (BSP_EN && i == 3) continue;
      step(vecs[i].code, 1'b1, 1'b1, 1'b0, "map");
      check("map.out", 32'(chr_data), 32'(vecs[i].exp));
      check("map.vld", 32'(chr_valid), 1);
    end
    step(6'h00, 1'b0, 1'b1, 1'b0, "drain0");

    // Fill to full, then drop one
    for (int i = 0; i < 9; i++) step(6'(4'hF - 4'(i)), 1'b1, 1'b0, 1'b0, "fill");
    check("fill.count8", 32'(count), 8);
    check("fill.ovf", 32'(overflow), 1);
    step(6'h02, 1'b1, 1'b0, 1'b1, "setwins");
    step(6'h00, 1'b0, 1'b0, 1'b1, "clr");
    check("clr.ovf", 32'(overflow), 0);
    step(6'h03, 1'b1, 1'b1, 1'b0, "fullpp");
    check("fullpp.count", 32'(count), 8);
    check("fullpp.ovf", 32'(overflow), 0);
    for (int i = 0; i < 8; i++) step(6'h00, 1'b0, 1'b1, 1'b0, "drain1");

    // Asynchronous reset with five entries held
    for (int i = 0; i < 5; i++) step(6'(4'h9 + 4'(i)), 1'b1, 1'b0, 1'b0, "pre");
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(count), 0);
    check("arst.valid", 32'(chr_valid), 0);
    q.delete(); ovf_m = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    step(6'h08, 1'b1, 1'b0, 1'b0, "post");
    check("post.data", 32'(chr_data), 32'h37);
    step(6'h00, 1'b0, 1'b1, 1'b0, "drain2");

    // Idx 14 after two keys, then idx 14 on an empty FIFO
    step(6'h0E, 1'b1, 1'b0, 1'b0, "bs1");
    step(6'h0D, 1'b1, 1'b0, 1'b0, "bs2");
    step(6'h01, 1'b1, 1'b0, 1'b0, "bs3");
    check("bs.count", 32'(count), BSP_EN ? 1 : 3);
    check("bs.head", 32'(chr_data), 32'h31);
    for (int i = 0; i < 3; i++) step(6'h00, 1'b0, 1'b1, 1'b0, "drain3");
    step(6'h01, 1'b1, 1'b0, 1'b0, "bsempty");
    check("bsempty.ovf", 32'(overflow), 0);
    step(6'h0E, 1'b1, 1'b1, 1'b0, "bspop1a");
    step(6'h01, 1'b1, 1'b1, 1'b0, "bspop1b");
    for (int i = 0; i < 3; i++) step(6'h00, 1'b0, 1'b1, 1'b0, "drain4");

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      logic [5:0] c;
      c = ($urandom_range(0, 9) == 0) ? 6'($urandom) : {2'b00, 4'($urandom)};
      step(c, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
